// File: rtl/writeback_if.sv
// writeback_if: commit, source-select and register read bus of the writeback stage
interface writeback_if #(parameter int DATA_W = 16, parameter int AW = 3);
  logic              enable_writeback;
  logic [1:0]        W_Control;
  logic [DATA_W-1:0] aluout;
  logic [DATA_W-1:0] memout;
  logic [DATA_W-1:0] pcout;
  logic [AW-1:0]     dr;
  logic [AW-1:0]     sr1;
  logic [AW-1:0]     sr2;
  logic [2:0]        psr;
  logic [DATA_W-1:0] vsr1;
  logic [DATA_W-1:0] vsr2;
  modport master (
    output enable_writeback, W_Control, aluout, memout, pcout, dr, sr1, sr2,
    input  psr, vsr1, vsr2
  );
  modport slave (
    input  enable_writeback, W_Control, aluout, memout, pcout, dr, sr1, sr2,
    output psr, vsr1, vsr2
  );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: LC-3 register file and NZP condition codes updated on commit
module writeback_stage #(
  parameter int         DATA_W    = 16,
  parameter int         NUM_REGS  = 8,
  parameter logic [2:0] RESET_PSR = 3'b000
) (
  input  logic clock,
  input  logic reset,
  writeback_if.slave wb
);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] wb_val;
  logic [2:0]        psr_next;
  logic              commit;
  always_comb begin
    wb_val   = wb.W_Control == 2'd0 ? wb.aluout : wb.W_Control == 2'd1 ? wb.memout : wb.pcout;
    commit   = wb.enable_writeback && wb.W_Control != 2'd3;
    psr_next = wb_val[DATA_W-1] ? 3'b100 : wb_val == '0 ? 3'b010 : 3'b001;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wb.psr <= RESET_PSR;
    end else if (commit) begin
      regs[wb.dr] <= wb_val;
      wb.psr      <= psr_next;
    end
  end
  // reads see registered state only; a same-cycle write shows up after the edge
  assign wb.vsr1 = regs[wb.sr1];
  assign wb.vsr2 = regs[wb.sr2];
  a_psr_legal: assert property (@(posedge clock) $onehot(wb.psr) || wb.psr == RESET_PSR);
  a_psr_hold:  assert property (@(posedge clock) !$past(reset) && !$past(commit) |-> $stable(wb.psr));
  a_dr_known:  assert property (@(posedge clock) !reset && commit |-> !$isunknown(wb.dr));
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed checks of register file writes, reads and condition codes
module tb_writeback_stage;
  logic clock = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  writeback_if #(.DATA_W(16), .AW(3)) wb ();
  writeback_stage #(.DATA_W(16), .NUM_REGS(8), .RESET_PSR(3'b000)) dut (
    .clock(clock), .reset(reset), .wb(wb.slave)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic idle();
    wb.enable_writeback = 0;
    wb.W_Control = 2'd0;
  endtask
  task automatic commit(input logic [1:0] w, input logic [15:0] v, input logic [2:0] d);
    wb.enable_writeback = 1;
    wb.W_Control = w;
    wb.aluout = w == 2'd0 ? v : 16'h0bad;
    wb.memout = w == 2'd1 ? v : 16'h0bad;
    wb.pcout  = w == 2'd2 ? v : 16'h0bad;
    wb.dr = d;
  endtask
  task automatic test_reset();
    reset = 1;
    tick();
    reset = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        wb.sr1 = 3'(a);
        wb.sr2 = 3'(b);
        #1;
        checks++;
        if (wb.vsr1 !== 16'h0000 || wb.vsr2 !== 16'h0000) begin
          errors++;
          $display("FAIL reset_read sr1=%0d sr2=%0d got %h/%h want 0000/0000", a, b, wb.vsr1, wb.vsr2);
        end
      end
    checks++;
    if (wb.psr !== 3'b000) begin errors++; $display("FAIL reset_psr got %b want 000", wb.psr); end
  endtask
  task automatic test_alu_mem();
    commit(2'd0, 16'h8001, 3'd3);
    tick();
    idle();
    wb.sr1 = 3'd3;
    #1;
    checks++;
    if (wb.vsr1 !== 16'h8001) begin errors++; $display("FAIL alu_write got %h want 8001", wb.vsr1); end
    checks++;
    if (wb.psr !== 3'b100) begin errors++; $display("FAIL alu_psr got %b want 100", wb.psr); end
    commit(2'd1, 16'h0000, 3'd3);
    tick();
    idle();
    checks++;
    if (wb.vsr1 !== 16'h0000) begin errors++; $display("FAIL mem_write got %h want 0000", wb.vsr1); end
    checks++;
    if (wb.psr !== 3'b010) begin errors++; $display("FAIL mem_psr got %b want 010", wb.psr); end
  endtask
  task automatic test_pc_no_bypass();
    wb.sr2 = 3'd7;
    commit(2'd2, 16'h3005, 3'd7);
    #1;
    checks++;
    if (wb.vsr2 !== 16'h0000) begin errors++; $display("FAIL no_bypass got %h want 0000", wb.vsr2); end
    tick();
    idle();
    checks++;
    if (wb.vsr2 !== 16'h3005) begin errors++; $display("FAIL pc_write got %h want 3005", wb.vsr2); end
    checks++;
    if (wb.psr !== 3'b001) begin errors++; $display("FAIL pc_psr got %b want 001", wb.psr); end
  endtask
  task automatic test_hold();
    commit(2'd0, 16'hffff, 3'd1);
    wb.enable_writeback = 0;
    wb.sr1 = 3'd1;
    tick();
    checks++;
    if (wb.vsr1 !== 16'h0000 || wb.psr !== 3'b001) begin
      errors++; $display("FAIL hold_disabled got %h/%b want 0000/001", wb.vsr1, wb.psr);
    end
    commit(2'd0, 16'hffff, 3'd1);
    wb.W_Control = 2'd3;
    tick();
    idle();
    checks++;
    if (wb.vsr1 !== 16'h0000 || wb.psr !== 3'b001) begin
      errors++; $display("FAIL hold_reserved got %h/%b want 0000/001", wb.vsr1, wb.psr);
    end
  endtask
  task automatic test_reset_mid();
    commit(2'd0, 16'h1234, 3'd2);
    tick();
    wb.sr1 = 3'd2;
    #1;
    checks++;
    if (wb.vsr1 !== 16'h1234) begin errors++; $display("FAIL pre_reset_write got %h want 1234", wb.vsr1); end
    commit(2'd0, 16'h5555, 3'd2);
    reset = 1;
    tick();
    reset = 0;
    idle();
    wb.sr2 = 3'd7;
    #1;
    checks++;
    if (wb.vsr1 !== 16'h0000) begin errors++; $display("FAIL reset_mid_r2 got %h want 0000", wb.vsr1); end
    checks++;
    if (wb.vsr2 !== 16'h0000) begin errors++; $display("FAIL reset_mid_r7 got %h want 0000", wb.vsr2); end
    checks++;
    if (wb.psr !== 3'b000) begin errors++; $display("FAIL reset_mid_psr got %b want 000", wb.psr); end
  endtask
  task automatic test_back_to_back();
    logic [15:0] exp1, exp2;
    for (int i = 0; i < 8; i++) begin
      commit(2'd0, 16'(16'h0101 * i), 3'(i));
      tick();
      checks++;
      if (wb.psr !== (i == 0 ? 3'b010 : 3'b001)) begin
        errors++; $display("FAIL b2b_psr i=%0d got %b want %b", i, wb.psr, i == 0 ? 3'b010 : 3'b001);
      end
    end
    idle();
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        wb.sr1 = 3'(a);
        wb.sr2 = 3'(b);
        exp1 = 16'(16'h0101 * a);
        exp2 = 16'(16'h0101 * b);
        #1;
        checks++;
        if (wb.vsr1 !== exp1 || wb.vsr2 !== exp2) begin
          errors++; $display("FAIL b2b_read sr1=%0d sr2=%0d got %h/%h want %h/%h", a, b, wb.vsr1, wb.vsr2, exp1, exp2);
        end
      end
    commit(2'd0, 16'h7000, 3'd4);
    tick();
    commit(2'd1, 16'hc001, 3'd4);
    tick();
    idle();
    wb.sr1 = 3'd4;
    wb.sr2 = 3'd4;
    #1;
    checks++;
    if (wb.vsr1 !== 16'hc001 || wb.vsr2 !== 16'hc001) begin
      errors++; $display("FAIL same_dr_last_wins got %h/%h want c001/c001", wb.vsr1, wb.vsr2);
    end
    checks++;
    if (wb.psr !== 3'b100) begin errors++; $display("FAIL same_dr_psr got %b want 100", wb.psr); end
  endtask
  initial begin
    idle();
    wb.aluout = 0;
    wb.memout = 0;
    wb.pcout = 0;
    wb.dr = 0;
    wb.sr1 = 0;
    wb.sr2 = 0;
    test_reset();
    test_alu_mem();
    test_pc_no_bypass();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
